// File: rtl/gray_histogram_pkg.sv
// Shared types and constants for the grayscale histogram block.
package gray_histogram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_BINS     = 256;
  localparam int DRAIN_CYCLES = 2;

  function automatic int num_pixels(input int w, input int h);
    return w * h;
  endfunction

  localparam int NUM_PIX = num_pixels(512, 512);

endpackage

// File: rtl/histogram_bin_ram.sv
// Bin storage: one write port, one synchronous read port for the increment
// pipeline (read-old on collision) and one registered read port for readout.
module histogram_bin_ram
  import gray_histogram_pkg::*;
#(
  parameter int CNT_W = 19,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [CNT_W-1:0] rd_data,
  input  logic [AW-1:0]    ro_addr,
  output logic [CNT_W-1:0] ro_data
);

  logic [CNT_W-1:0] mem [NUM_BINS];

  // Write port; contents are deliberately not reset, only the CLEAR phase zeroes them.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Pipeline read port; nonblocking semantics give the old value on a same-address write.
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
  end

  // Readout port, registered with a resettable output so it reads 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) ro_data <= '0;
    else       ro_data <= mem[ro_addr];
  end

endmodule

// File: rtl/gray_histogram.sv
// Scans the grayscale image RAM once per run and builds a 256-bin histogram
// at one pixel per cycle, forwarding back-to-back updates to the same bin.
module gray_histogram
  import gray_histogram_pkg::*;
#(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8,
  parameter int CNT_W  = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  output logic              io_busy,
  output logic              io_done,
  output logic [ADDR_W-1:0] io_gray_addr,
  input  logic [PIX_W-1:0]  io_gray_data,
  input  logic [PIX_W-1:0]  io_hist_addr,
  output logic [CNT_W-1:0]  io_hist_data
);

  localparam int N = num_pixels(IMG_W, IMG_H);

  state_t           state;
  logic [PIX_W-1:0] clr_cnt;
  logic [1:0]       drain_cnt;

  logic             s1_valid;
  logic             s2_valid;
  logic [PIX_W-1:0] s2_bin;
  logic             fwd_hit;
  logic [CNT_W-1:0] fwd_val;
  logic [CNT_W-1:0] bin_rd;
  logic [CNT_W-1:0] bin_base;
  logic [CNT_W-1:0] bin_inc;

  logic             ram_we;
  logic [PIX_W-1:0] ram_waddr;
  logic [CNT_W-1:0] ram_wdata;

  // Run sequencing: state, clear/scan/drain counters and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      drain_cnt    <= '0;
      io_gray_addr <= '0;
      io_busy      <= 1'b0;
      io_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            io_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == '1) begin
            state        <= SCAN;
            io_gray_addr <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        SCAN: begin
          if (io_gray_addr == ADDR_W'(N - 1)) begin
            state        <= DRAIN;
            io_gray_addr <= '0;
            drain_cnt    <= '0;
          end else begin
            io_gray_addr <= io_gray_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            state   <= DONE;
            io_busy <= 1'b0;
            io_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!io_start) begin
            state   <= IDLE;
            io_done <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          io_busy <= 1'b0;
          io_done <= 1'b0;
        end
      endcase
    end
  end

  assign bin_base = fwd_hit ? fwd_val : bin_rd;
  assign bin_inc  = bin_base + CNT_W'(1);

  // Increment pipeline: S1 holds the arriving pixel, S2 holds the bin being written;
  // a same-bin S1/S2 pair takes the S2 write value instead of the stale RAM word.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      fwd_hit  <= 1'b0;
      fwd_val  <= '0;
    end else begin
      s1_valid <= (state == SCAN);
      s2_valid <= s1_valid;
      s2_bin   <= io_gray_data;
      fwd_hit  <= s1_valid && s2_valid && (io_gray_data == s2_bin);
      fwd_val  <= bin_inc;
    end
  end

  // Write-port source: zeroing sweep during CLEAR, otherwise the S2 increment.
  always_comb begin
    ram_we    = s2_valid;
    ram_waddr = s2_bin;
    ram_wdata = bin_inc;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end
  end

  histogram_bin_ram #(
    .CNT_W(CNT_W),
    .AW   (PIX_W)
  ) u_bins (
    .clock  (clock),
    .reset  (reset),
    .we     (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata),
    .rd_addr(io_gray_data),
    .rd_data(bin_rd),
    .ro_addr(io_hist_addr),
    .ro_data(io_hist_data)
  );

endmodule

// File: tb/tb_gray_histogram.sv
// Directed self-checking bench for gray_histogram on a reduced 32x24 image.
module tb_gray_histogram;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 24;
  localparam int N         = IMG_W * IMG_H;
  localparam int ADDR_W    = 18;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 19;
  localparam int RUN_LIMIT = 2000;

  logic              clock;
  logic              reset;
  logic              io_start;
  logic              io_busy;
  logic              io_done;
  logic [ADDR_W-1:0] io_gray_addr;
  logic [PIX_W-1:0]  io_gray_data;
  logic [PIX_W-1:0]  io_hist_addr;
  logic [CNT_W-1:0]  io_hist_data;

  int tests;
  int failures;
  int mode;
  int done_cycle;
  int busy_cycles;
  int overlap;
  int addr_err;
  logic [CNT_W-1:0] got [256];

  gray_histogram #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_gray_addr(io_gray_addr),
    .io_gray_data(io_gray_data),
    .io_hist_addr(io_hist_addr),
    .io_hist_data(io_hist_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Image pattern generator: 0 = all 0x80, 1 = ramp, 2 = 00,00,FF repeating, 3 = all 0x00.
  function automatic logic [7:0] pix(input int m, input int a);
    case (m)
      0:       return 8'h80;
      1:       return 8'(a % 256);
      2:       return (a % 3 == 2) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Reference count of one bin for a given pattern.
  function automatic int model_bin(input int m, input int b);
    int c;
    c = 0;
    for (int a = 0; a < N; a++) if (int'(pix(m, a)) == b) c++;
    return c;
  endfunction

  // Grayscale RAM model with one cycle of read latency.
  always @(posedge clock) io_gray_data <= pix(mode, int'(io_gray_addr));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts one run and follows it cycle by cycle until io_done or the cycle budget expires.
  task automatic applyStimulus(input int m, input bit hold);
    int  k;
    bit  seen_done;
    mode        = m;
    done_cycle  = 0;
    busy_cycles = 0;
    overlap     = 0;
    addr_err    = 0;
    seen_done   = 1'b0;
    k           = 0;
    @(negedge clock);
    io_start = 1'b1;
    while (!seen_done && k < RUN_LIMIT) begin
      @(negedge clock);
      k++;
      if (!hold) io_start = 1'b0;
      if (io_busy) busy_cycles++;
      if (io_busy && io_done) overlap++;
      if (k >= 257 && k <= 256 + N) begin
        if (io_gray_addr !== ADDR_W'(k - 257)) addr_err++;
      end else if (io_gray_addr !== '0) begin
        addr_err++;
      end
      if (io_done) begin
        seen_done  = 1'b1;
        done_cycle = k;
      end
    end
  endtask

  // Reads all 256 bins with back-to-back addresses.
  task automatic dumpHistogram();
    @(negedge clock);
    io_hist_addr = '0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      got[i] = io_hist_data;
      if (i < 255) io_hist_addr = 8'(i + 1);
    end
  endtask

  task automatic checkHistogram(input string prefix, input int m);
    int bad;
    int sum;
    bad = 0;
    sum = 0;
    for (int b = 0; b < 256; b++) begin
      sum += int'(got[b]);
      if (int'(got[b]) != model_bin(m, b)) bad++;
    end
    checkOutput({prefix, "_bad_bins"}, bad, 0);
    checkOutput({prefix, "_sum"}, sum, N);
  endtask

  initial begin
    tests        = 0;
    failures     = 0;
    mode         = 3;
    reset        = 1'b1;
    io_start     = 1'b0;
    io_hist_addr = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", io_busy, 0);
    checkOutput("reset_done", io_done, 0);
    checkOutput("reset_gray_addr", io_gray_addr, 0);
    checkOutput("reset_hist_data", io_hist_data, 0);
    reset = 1'b0;
    @(negedge clock);

    // Uniform 0x80 image with full timing checks.
    applyStimulus(0, 1'b0);
    checkOutput("uni_done_cycle", done_cycle, N + 259);
    checkOutput("uni_busy_cycles", busy_cycles, N + 258);
    checkOutput("uni_busy_done_overlap", overlap, 0);
    checkOutput("uni_addr_sweep", addr_err, 0);
    dumpHistogram();
    checkOutput("uni_bin128", got[128], 768);
    checkOutput("uni_bin127", got[127], 0);
    checkHistogram("uni", 0);

    // Ramp image: every bin gets N/256.
    applyStimulus(1, 1'b0);
    checkOutput("ramp_done_cycle", done_cycle, N + 259);
    dumpHistogram();
    checkOutput("ramp_bin0", got[0], 3);
    checkOutput("ramp_bin255", got[255], 3);
    checkHistogram("ramp", 1);

    // Period-3 pattern 00,00,FF.
    applyStimulus(2, 1'b0);
    dumpHistogram();
    checkOutput("p3_bin0", got[0], 512);
    checkOutput("p3_bin255", got[255], 256);
    checkOutput("p3_bin1", got[1], 0);
    checkHistogram("p3", 2);

    // Re-run with an all-zero image, holding start high through DONE.
    applyStimulus(3, 1'b1);
    checkOutput("zero_done_cycle", done_cycle, N + 259);
    repeat (3) @(negedge clock);
    checkOutput("hold_done_stays", io_done, 1);
    checkOutput("hold_no_restart", io_busy, 0);
    io_start = 1'b0;
    @(negedge clock);
    checkOutput("release_done_low", io_done, 0);
    checkOutput("release_busy_low", io_busy, 0);
    dumpHistogram();
    checkOutput("rerun_bin0", got[0], 768);
    checkOutput("rerun_bin1", got[1], 0);
    checkHistogram("rerun", 3);

    // Reset in the middle of SCAN, then a clean ramp run.
    mode = 1;
    @(negedge clock);
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    repeat (998) @(negedge clock);
    checkOutput("mid_busy_before_reset", io_busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mid_reset_busy", io_busy, 0);
    checkOutput("mid_reset_done", io_done, 0);
    checkOutput("mid_reset_gray_addr", io_gray_addr, 0);
    checkOutput("mid_reset_hist_data", io_hist_data, 0);
    @(negedge clock);
    checkOutput("mid_reset_idle", io_busy, 0);
    applyStimulus(1, 1'b0);
    checkOutput("after_reset_done_cycle", done_cycle, N + 259);
    dumpHistogram();
    checkOutput("after_reset_bin77", got[77], 3);
    checkHistogram("after_reset", 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
